// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and pipe-register controls of the pipeline controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, id_uses_rt, id_halt, ex_redirect, wb_halt;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halt;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt, id_halt, ex_redirect, wb_halt,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input halt, stall_cnt, redir_cnt
  );
  modport slave (
    input ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt, id_uses_rt, id_halt, ex_redirect, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output halt, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage pipe, with halt drain and debug counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic nRST,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, nxt;
  logic mem_wait, load_use, stall_inc, redir_inc;
  assign mem_wait = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
  assign load_use = bus.ex_dREN & (bus.ex_wsel != 5'd0) &
                    ((bus.ex_wsel == bus.id_rs) | (bus.id_uses_rt & (bus.ex_wsel == bus.id_rt)));
  always_comb begin
    nxt = state;
    stall_inc = 1'b0;
    redir_inc = 1'b0;
    {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = '1;
    {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = '0;
    if (!nRST) begin
      {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = '0;
      {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = '1;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en} = '0;
            bus.memwb_flush = 1'b1;
            stall_inc = 1'b1;
          end else if (bus.ex_redirect) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            redir_inc = 1'b1;
          end else if (load_use) begin
            bus.pc_en = 1'b0;
            bus.ifid_en = 1'b0;
            bus.idex_flush = 1'b1;
            stall_inc = 1'b1;
          end else if (!bus.ihit) begin
            bus.pc_en = 1'b0;
            bus.ifid_flush = 1'b1;
            stall_inc = 1'b1;
          end else if (bus.id_halt) begin
            nxt = DRAIN;
          end
        end
        DRAIN: begin
          bus.pc_en = 1'b0;
          bus.ifid_en = 1'b0;
          bus.ifid_flush = 1'b1;
          if (mem_wait) begin
            bus.idex_en = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_flush = 1'b1;
            stall_inc = 1'b1;
          end
          if (bus.wb_halt) nxt = HALTED;
        end
        default: begin
          {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = '0;
          nxt = HALTED;
        end
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
      bus.halt <= 1'b0;
      bus.stall_cnt <= '0;
      bus.redir_cnt <= '0;
    end else begin
      state <= nxt;
      bus.halt <= (nxt == HALTED);
      bus.stall_cnt <= (stall_inc && !(&bus.stall_cnt)) ? bus.stall_cnt + 1'b1 : bus.stall_cnt;
      bus.redir_cnt <= (redir_inc && !(&bus.redir_cnt)) ? bus.redir_cnt + 1'b1 : bus.redir_cnt;
    end
  end
endmodule
